// File: rtl/partial_fm_accumulate_pool.sv
// partial_fm_accumulate_pool
//   Accumulates the three Q1.15 partial feature maps of each input channel
//   into 20-bit saturating accumulators, then on the last channel adds a
//   per-kernel bias, clamps to Q1.15, applies ReLU and 2x2/stride-2 max-pools
//   the three maps.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   pfm_valid         partial FM set on IK1..IK3 valid this cycle
//   pfm_last          with pfm_valid: final input channel of the frame
//   ready             block can accept a partial FM set
//   IK1..IK3          flattened partial FMs, element e at [16*e +: 16]
//   B1..B3            per-kernel bias, used during FIN
//   P1..P3            flattened pooled maps, element p at [16*p +: 16]
//   done              one-cycle pulse, P1..P3 newly valid
//
// state | meaning
// IDLE  | waiting for a partial FM set (ready=1)
// ACC   | adding captured set into accumulators, one element per cycle
// FIN   | bias + clamp + ReLU, result written back in place
// POOL  | 2x2 max-pool, one pooled element per cycle into shadow buffer
// DONE  | done pulse, accumulators cleared
module partial_fm_accumulate_pool #(
  parameter int op_size       = 4,
  parameter int pool_size     = op_size / 2,
  parameter int total_outputs = op_size * op_size,
  parameter int total_pooled  = pool_size * pool_size
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pfm_valid,
  input  logic                        pfm_last,
  output logic                        ready,
  input  logic [16*total_outputs-1:0] IK1,
  input  logic [16*total_outputs-1:0] IK2,
  input  logic [16*total_outputs-1:0] IK3,
  input  logic [15:0]                 B1,
  input  logic [15:0]                 B2,
  input  logic [15:0]                 B3,
  output logic [16*total_pooled-1:0]  P1,
  output logic [16*total_pooled-1:0]  P2,
  output logic [16*total_pooled-1:0]  P3,
  output logic                        done
);

  localparam int IW = (total_outputs > 1) ? $clog2(total_outputs) : 1;
  localparam logic [IW-1:0] LAST_E = IW'(total_outputs - 1);
  localparam logic [IW-1:0] LAST_P = IW'(total_pooled - 1);

  typedef enum logic [2:0] {IDLE, ACC, FIN, POOL, DONE} state_t;

  state_t                      state_q, state_d;
  logic [IW-1:0]               cnt_q;
  logic                        last_q;
  logic [15:0]                 buf_q   [3][total_outputs];
  logic signed [19:0]          acc_q   [3][total_outputs];
  logic [16*total_pooled-1:0]  shadow_q   [3];
  logic [16*total_pooled-1:0]  shadow_upd [3];
  logic [16*total_pooled-1:0]  pout_q     [3];

  logic [16*total_outputs-1:0] ik_in [3];
  logic [15:0]                 bias  [3];
  logic signed [20:0]          acc_sum  [3];
  logic signed [20:0]          fin_sum  [3];
  logic signed [19:0]          acc_nxt  [3];
  logic [15:0]                 fin_nxt  [3];
  logic [15:0]                 pool_max [3];
  logic [IW-1:0]               px, py, e00;

  assign ik_in[0] = IK1;
  assign ik_in[1] = IK2;
  assign ik_in[2] = IK3;
  assign bias[0]  = B1;
  assign bias[1]  = B2;
  assign bias[2]  = B3;
  assign P1 = pout_q[0];
  assign P2 = pout_q[1];
  assign P3 = pout_q[2];

  function automatic logic [15:0] max2(input logic [15:0] a, input logic [15:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (pfm_valid) state_d = ACC;
      end
      ACC:  if (cnt_q == LAST_E) state_d = last_q ? FIN : IDLE;
      FIN:  if (cnt_q == LAST_E) state_d = POOL;
      POOL: if (cnt_q == LAST_P) state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Element datapath. After FIN every accumulator holds a non-negative
  // 16-bit value in its low half, which POOL reads back.
  always_comb begin
    px  = cnt_q % IW'(pool_size);
    py  = cnt_q / IW'(pool_size);
    e00 = IW'(2) * px + IW'(2 * op_size) * py;
    for (int k = 0; k < 3; k++) begin
      acc_sum[k] = $signed({acc_q[k][cnt_q][19], acc_q[k][cnt_q]})
                 + $signed({{5{buf_q[k][cnt_q][15]}}, buf_q[k][cnt_q]});
      if (acc_sum[k][20] != acc_sum[k][19])
        acc_nxt[k] = acc_sum[k][20] ? 20'sh80000 : 20'sh7FFFF;
      else
        acc_nxt[k] = acc_sum[k][19:0];

      fin_sum[k] = $signed({acc_q[k][cnt_q][19], acc_q[k][cnt_q]})
                 + $signed({{5{bias[k][15]}}, bias[k]});
      if (fin_sum[k][20])
        fin_nxt[k] = 16'h0000;
      else if (fin_sum[k] > 21'sd32767)
        fin_nxt[k] = 16'h7FFF;
      else
        fin_nxt[k] = fin_sum[k][15:0];

      pool_max[k] = max2(max2(acc_q[k][e00][15:0],
                              acc_q[k][e00 + IW'(1)][15:0]),
                         max2(acc_q[k][e00 + IW'(op_size)][15:0],
                              acc_q[k][e00 + IW'(op_size + 1)][15:0]));
      shadow_upd[k] = shadow_q[k];
      shadow_upd[k][16*cnt_q +: 16] = pool_max[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        shadow_q[k] <= '0;
        pout_q[k]   <= '0;
        for (int e = 0; e < total_outputs; e++) acc_q[k][e] <= '0;
      end
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (pfm_valid) begin
            last_q <= pfm_last;
            cnt_q  <= '0;
            for (int k = 0; k < 3; k++)
              for (int e = 0; e < total_outputs; e++)
                buf_q[k][e] <= ik_in[k][16*e +: 16];
          end
        end
        ACC: begin
          for (int k = 0; k < 3; k++) acc_q[k][cnt_q] <= acc_nxt[k];
          cnt_q <= (cnt_q == LAST_E) ? '0 : cnt_q + 1'b1;
        end
        FIN: begin
          for (int k = 0; k < 3; k++) acc_q[k][cnt_q] <= {4'b0000, fin_nxt[k]};
          cnt_q <= (cnt_q == LAST_E) ? '0 : cnt_q + 1'b1;
        end
        POOL: begin
          for (int k = 0; k < 3; k++) shadow_q[k] <= shadow_upd[k];
          // Outputs are loaded together with the final pooled element so
          // they are already valid in the cycle done is high.
          if (cnt_q == LAST_P) begin
            for (int k = 0; k < 3; k++) pout_q[k] <= shadow_upd[k];
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          for (int k = 0; k < 3; k++)
            for (int e = 0; e < total_outputs; e++) acc_q[k][e] <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_partial_fm_accumulate_pool.sv
// Bench for partial_fm_accumulate_pool (op_size=4).
// Expected pooled maps are computed by a small integer model when the last
// channel of a frame is accepted, queued, and compared when done pulses.
module tb_partial_fm_accumulate_pool;
  localparam int N = 16;
  localparam int P = 4;

  logic         clk = 1'b0;
  logic         rst, pfm_valid, pfm_last, ready, done;
  logic [255:0] ik1, ik2, ik3;
  logic [15:0]  b1, b2, b3;
  logic [63:0]  p1, p2, p3;

  int           n_vec = 0;
  int           n_err = 0;
  logic [191:0] sb[$];
  int           macc [3][N];

  always #5 clk = ~clk;

  partial_fm_accumulate_pool #(.op_size(4)) dut (
    .clk(clk), .rst(rst), .pfm_valid(pfm_valid), .pfm_last(pfm_last),
    .ready(ready), .IK1(ik1), .IK2(ik2), .IK3(ik3),
    .B1(b1), .B2(b2), .B3(b3), .P1(p1), .P2(p2), .P3(p3), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int sx16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic logic [255:0] fill(input logic [15:0] v);
    return {16{v}};
  endfunction

  function automatic logic [255:0] ramp();
    logic [255:0] r;
    for (int e = 0; e < N; e++) r[16*e +: 16] = 16'(16 * e);
    return r;
  endfunction

  function automatic logic [255:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++)
      for (int e = 0; e < N; e++) macc[k][e] = 0;
  endtask

  task automatic model_acc(input logic [255:0] a, input logic [255:0] b, input logic [255:0] c);
    logic [255:0] v [3];
    int s;
    v[0] = a; v[1] = b; v[2] = c;
    for (int k = 0; k < 3; k++)
      for (int e = 0; e < N; e++) begin
        s = macc[k][e] + sx16(v[k][16*e +: 16]);
        if (s > 524287)  s = 524287;
        if (s < -524288) s = -524288;
        macc[k][e] = s;
      end
  endtask

  task automatic model_fin();
    logic [15:0]  bs [3];
    int           r [3][N];
    int           m, v;
    logic [191:0] exp_v;
    bs[0] = b1; bs[1] = b2; bs[2] = b3;
    for (int k = 0; k < 3; k++)
      for (int e = 0; e < N; e++) begin
        v = macc[k][e] + sx16(bs[k]);
        if (v > 32767) v = 32767;
        if (v < 0)     v = 0;
        r[k][e] = v;
      end
    for (int k = 0; k < 3; k++)
      for (int py = 0; py < 2; py++)
        for (int px = 0; px < 2; px++) begin
          m = r[k][2*px + 8*py];
          if (r[k][2*px + 1 + 8*py] > m) m = r[k][2*px + 1 + 8*py];
          if (r[k][2*px + 4 + 8*py] > m) m = r[k][2*px + 4 + 8*py];
          if (r[k][2*px + 5 + 8*py] > m) m = r[k][2*px + 5 + 8*py];
          exp_v[64*k + 16*(px + 2*py) +: 16] = 16'(m);
        end
    sb.push_back(exp_v);
    model_clear();
  endtask

  always @(negedge clk) begin : mon
    logic [191:0] e, g;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        g = {p3, p2, p1};
        for (int k = 0; k < 3; k++)
          for (int p = 0; p < P; p++)
            chk($sformatf("P%0d[%0d]", k + 1, p),
                {16'h0, g[64*k + 16*p +: 16]}, {16'h0, e[64*k + 16*p +: 16]});
      end
    end
  end

  // poke: cycle after accept at which a stray pfm_valid is pulsed (0 = none)
  // rst_at: cycle after accept after which rst is held for one edge (0 = none)
  task automatic send(input logic [255:0] a, input logic [255:0] b, input logic [255:0] c,
                      input logic last, input int poke, input int rst_at);
    int n;
    n = 0;
    while (!ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("rdy_wait", {31'b0, ready}, 32'd1);
    ik1 = a; ik2 = b; ik3 = c; pfm_last = last; pfm_valid = 1'b1;
    @(posedge clk);
    #1;
    pfm_valid = 1'b0;
    ik1 = rnd(); ik2 = rnd(); ik3 = rnd(); pfm_last = 1'($urandom);
    model_acc(a, b, c);
    if (last) model_fin();
    for (n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (n == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_done",  {31'b0, done},  32'd0);
        chk("rst_P",     {31'b0, |{p1, p2, p3}}, 32'd0);
        if (last && sb.size() > 0) sb.delete(sb.size() - 1);
        model_clear();
        return;
      end
      if (ready || done) break;
      if (n == poke) begin
        pfm_valid = 1'b1;
        ik1 = fill(16'h7FFF); ik2 = fill(16'h7FFF); ik3 = fill(16'h7FFF);
      end else begin
        pfm_valid = 1'b0;
      end
    end
    pfm_valid = 1'b0;
    if (last) begin
      chk("done_lat", 32'(n), 32'd36);
      chk("rdy_in_done", {31'b0, ready}, 32'd0);
      @(posedge clk); #1;
      chk("rdy_after_done", {31'b0, ready}, 32'd1);
      chk("done_one_cycle", {31'b0, done}, 32'd0);
    end else begin
      chk("rdy_lat", 32'(n), 32'd16);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int nch;
    rst = 1'b1; pfm_valid = 1'b0; pfm_last = 1'b0;
    ik1 = '0; ik2 = '0; ik3 = '0; b1 = '0; b2 = '0; b3 = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_ready", {31'b0, ready}, 32'd1);
    chk("reset_done",  {31'b0, done},  32'd0);
    chk("reset_P",     {31'b0, |{p1, p2, p3}}, 32'd0);

    // single channel: plain, ReLU, ramp
    send(fill(16'h1000), fill(16'hC000), ramp(), 1'b1, 0, 0);

    // three channels, clamp to 0x7FFF
    send(fill(16'h7000), rnd(), fill(16'h3000), 1'b0, 0, 0);
    send(fill(16'h7000), rnd(), fill(16'h3000), 1'b0, 0, 0);
    send(fill(16'h7000), rnd(), fill(16'h3000), 1'b1, 0, 0);

    // bias: positive overflow clamp and negative to zero
    b1 = 16'h2000; b2 = 16'h8000; b3 = 16'($urandom);
    send(fill(16'h7000), fill(16'h1000), rnd(), 1'b1, 0, 0);
    b1 = '0; b2 = '0; b3 = '0;

    // 20-bit accumulator saturation is visible once negative channels follow
    repeat (20) send(fill(16'h7FFF), fill(16'h0100), ramp(), 1'b0, 0, 0);
    repeat (15) send(fill(16'h8000), fill(16'h0100), ramp(), 1'b0, 0, 0);
    send(fill(16'hF000), fill(16'h0100), ramp(), 1'b1, 0, 0);

    // stray pfm_valid while busy
    send(ramp(), fill(16'h2000), fill(16'h0800), 1'b0, 5, 0);
    send(fill(16'h0010), ramp(), fill(16'h0400), 1'b1, 5, 0);

    // reset mid-frame, then clean frames
    send(rnd(), rnd(), rnd(), 1'b0, 0, 0);
    send(rnd(), rnd(), rnd(), 1'b1, 0, 19);
    send(ramp(), fill(16'h1234), fill(16'hFFFF), 1'b1, 0, 0);

    repeat (3) begin
      b1 = 16'($urandom); b2 = 16'($urandom); b3 = 16'($urandom_range(0, 16'h0FFF));
      nch = $urandom_range(1, 3);
      for (int i = 1; i <= nch; i++)
        send(rnd(), rnd(), rnd(), 1'(i == nch), 0, 0);
    end

    repeat (4) @(posedge clk);
    #1 chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
